uart_tx_sniffer: RTL and testbench
==================================

# uart_tx_sniffer

Synthesizable 8N1 UART receiver that sits directly downstream of the SoC `UART_TX` pin and decodes the serial stream into bytes for the bench console, a result checker, or an on-FPGA loopback. It oversamples the line with a fixed divisor, validates start and stop bits, and buffers decoded bytes in a small FIFO drained through a valid/ready pop port. Sticky error flags report framing errors and FIFO overflow.

## Interface
- `CLKS_PER_BIT`, 434: `clk_in` cycles per UART bit; must be ≥ 4.
- `FIFO_DEPTH`, 16: byte FIFO entries; power of two, ≥ 2.
- `clk_in` in 1: the only clock; all logic is on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `uart_rx` in 1: serial line driven by the SoC `UART_TX`; idle high; asynchronous to `clk_in`.
- `rx_data` out 8: byte at the FIFO head; valid only while `rx_valid` is high.
- `rx_valid` out 1: FIFO not empty.
- `rx_ready` in 1: pop request; the head is popped on any cycle where `rx_valid && rx_ready`.
- `rx_count` out $clog2(FIFO_DEPTH)+1: current FIFO occupancy.
- `frame_err` out 1: sticky; set when a stop bit (or parity, if enabled) fails.
- `ovf_err` out 1: sticky; set when a byte arrives while the FIFO is full.
- `err_clr` in 1: a one-cycle pulse clears both sticky flags.

## Operation
- `uart_rx` passes through a 2-flop synchronizer. The synchronizer flops reset to 1.
- FSM states are IDLE, START, DATA, PARITY, STOP and WAIT_IDLE.
- IDLE: a falling edge on the synchronized line (1→0) loads the bit counter with CLKS_PER_BIT/2−1 and moves to START.
- START: at counter expiry, sample the line.
  - Sample 0: load CLKS_PER_BIT−1 and go to DATA.
  - Sample 1: false start. Return to IDLE with no flag set.
- DATA: sample one bit per CLKS_PER_BIT cycles, LSB first, into the shift register. After bit 7 go to PARITY (when configured) or STOP.
- STOP: sample the line at bit centre.
  - Sample 1 and FIFO not full (or popped this same cycle): push the byte and go to IDLE.
  - Sample 1 and FIFO full with no pop this cycle: drop the byte, set `ovf_err`, go to IDLE.
  - Sample 0: discard the byte, set `frame_err`, go to WAIT_IDLE.
- WAIT_IDLE: stay until the synchronized line reads 1, then go to IDLE. This prevents a break condition from re-triggering start detection.
- FIFO boundary rules:
  - Push and pop in the same cycle when full: both take effect, and `ovf_err` is not set.
  - A pop when empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH. A full/empty ambiguity is avoided with an extra pointer bit.
- Error flags:
  - If `err_clr` and a set event coincide, the set wins.
  - `err_clr` does not affect the FIFO or the FSM.
- Reset mid-frame: the FSM returns to IDLE and the FIFO empties. If the line is still low after reset, the sniffer waits for 1→0 and does not decode mid-frame.

## Timing
- Reset values:
  - `rx_valid`=0, `rx_count`=0, `rx_data`=0, `frame_err`=0, `ovf_err`=0.
  - FSM in IDLE; synchronizer flops at 1.
- Start detection lags the pin edge by 2 cycles (synchronizer) plus 1 cycle (edge detect).
- A byte is visible (`rx_valid`=1, `rx_data` updated) in the cycle after the stop-bit sample.
- Pop takes effect at the clock edge. The new head appears on `rx_data` in the next cycle, so there is no combinational ready→data path.
- `rx_data` is a registered FIFO-head read. It must not depend combinationally on `rx_ready`.
- Back-to-back frames: a new start edge is accepted starting the cycle after the STOP sample.

## Configuration
- Macro `UART_SNIFF_PARITY_EN`.
- Defined: frames are 8E1. After DATA the FSM enters PARITY, samples one bit, and checks even parity over the 8 data bits.
  - On mismatch, the byte is discarded, `frame_err` is set, and the FSM still goes to STOP to consume the stop bit.
- Not defined: the PARITY state and its logic are absent; frames are 8N1.

## Structure
- Package `uart_sniff_pkg` holds the FSM state enum, the bit-count constant (8), and the `FIFO_DEPTH`-derived width function.
- Sub-module `uart_sniff_fifo` is a synchronous FIFO with push/pop, full/empty, count and registered head. It is parameterized by width and depth.
- Top-level logic: synchronizer, FSM, baud counter, shift register and error flags.

## Test plan
All scenarios use CLKS_PER_BIT=8 and FIFO_DEPTH=4.
1. Send 0x55, then 0xA3, with `rx_ready`=0 → `rx_count`=2, `rx_data`=0x55. Pop once → `rx_data`=0xA3, `rx_count`=1.
2. Pulse `uart_rx` low for 3 cycles → no byte pushed, `frame_err`=0, FSM back in IDLE.
3. Send 0x41 with the stop bit forced to 0 → `frame_err`=1, `rx_count`=0. Hold low 40 cycles, release, then send 0x42 → `rx_data`=0x42.
4. Send 5 bytes 0x01..0x05 with no pops → `rx_count`=4, `ovf_err`=1, head 0x01. Repeat with a pop coinciding with the 5th stop sample → `ovf_err`=0.
5. Assert `rst` in the middle of DATA for 0x7E → all outputs at reset values. The next full frame 0x7E decodes correctly.
6. With `UART_SNIFF_PARITY_EN`:
   - 0x07 sent with parity bit 1 → accepted.
   - Same byte sent with parity bit 0 → `frame_err`=1, no push.

Source files
------------

// File: rtl/uart_sniff_pkg.sv
// Shared types and constants for the UART TX sniffer.
// UART_SNIFF_PARITY_EN adds the PARITY state (8E1 framing); without it frames are 8N1.
package uart_sniff_pkg;

    // Receiver FSM states; encodings are fixed so debug traces stay stable across builds.
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
`ifdef UART_SNIFF_PARITY_EN
        S_PARITY    = 3'd3,
`endif
        S_STOP      = 3'd4,
        S_WAIT_IDLE = 3'd5
    } sniff_state_e;

    // Data bits per frame.
    localparam int DATA_BITS = 8;

    // Width of an occupancy count able to hold 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_sniff_fifo.sv
// Synchronous FIFO with a registered head output.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// A pop on an empty FIFO is ignored; a push while full succeeds only if a pop
// takes effect in the same cycle.
module uart_sniff_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk_in,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      rd_next;
    logic             do_push;
    logic             do_pop;

    assign count   = wr_ptr - rd_ptr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_next = do_pop ? rd_ptr + (AW+1)'(1) : rd_ptr;

    // Storage write; contents need no reset because occupancy gates their use.
    always_ff @(posedge clk_in) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    // Read/write pointer update.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            rd_ptr <= rd_next;
        end
    end

    // Registered head: bypass the incoming word when it lands at the new head slot.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            head <= '0;
        end else if (do_push || do_pop) begin
            if (do_push && (rd_next[AW-1:0] == wr_ptr[AW-1:0])) begin
                head <= push_data;
            end else begin
                head <= mem[rd_next[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/uart_tx_sniffer.sv
// UART receiver that decodes the SoC UART_TX line into a byte FIFO.
// Optional macro UART_SNIFF_PARITY_EN switches framing from 8N1 to 8E1.
//
// Pop port handshake: rx_valid is high whenever the FIFO holds a byte and
// rx_data then shows the oldest byte; the byte is consumed at the rising edge
// of clk_in in any cycle where rx_valid && rx_ready. rx_data is registered and
// never depends on rx_ready in the same cycle.
module uart_tx_sniffer
    import uart_sniff_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                                clk_in,
    input  logic                                rst,
    input  logic                                uart_rx,
    output logic [7:0]                          rx_data,
    output logic                                rx_valid,
    input  logic                                rx_ready,
    output logic [count_width(FIFO_DEPTH)-1:0]  rx_count,
    output logic                                frame_err,
    output logic                                ovf_err,
    input  logic                                err_clr,
    output sniff_state_e                        fsm_state
);

    localparam int              CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             prev_q;
    logic [1:0]       settle_q;
    logic             line;
    logic             fall;

    sniff_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [2:0]       bit_q, bit_d;
`ifdef UART_SNIFF_PARITY_EN
    logic             par_bad_q, par_bad_d;
`endif

    logic             push;
    logic             frame_set;
    logic             ovf_set;
    logic             fifo_empty;
    logic             fifo_full;
    logic             pop_now;

    assign line      = sync2_q;
    // Edge detection is armed only once the chain holds real line samples, so
    // the reset value of the synchronizer can never fake a start edge.
    assign fall      = (settle_q == 2'd3) && prev_q && !line;
    assign rx_valid  = !fifo_empty;
    assign pop_now   = rx_valid && rx_ready;
    assign fsm_state = state_q;

    // Two-flop synchronizer, previous-sample register and post-reset settle count.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            prev_q   <= 1'b1;
            settle_q <= 2'd0;
        end else begin
            sync1_q <= uart_rx;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            if (settle_q != 2'd3) begin
                settle_q <= settle_q + 2'd1;
            end
        end
    end

    // Receiver next-state, baud counter, shift register and event decode.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        bit_d     = bit_q;
        push      = 1'b0;
        frame_set = 1'b0;
        ovf_set   = 1'b0;
`ifdef UART_SNIFF_PARITY_EN
        par_bad_d = par_bad_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (fall) begin
                    cnt_d   = HALF_BIT;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == '0) begin
                    if (!line) begin
                        cnt_d   = FULL_BIT;
                        bit_d   = 3'd0;
`ifdef UART_SNIFF_PARITY_EN
                        par_bad_d = 1'b0;
`endif
                        state_d = S_DATA;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == '0) begin
                    shift_d = {line, shift_q[7:1]};
                    cnt_d   = FULL_BIT;
                    if (bit_q == LAST_BIT) begin
`ifdef UART_SNIFF_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`ifdef UART_SNIFF_PARITY_EN
            S_PARITY: begin
                if (cnt_q == '0) begin
                    // Even parity: the parity bit must equal the XOR of the data bits.
                    if (line != (^shift_q)) begin
                        frame_set = 1'b1;
                        par_bad_d = 1'b1;
                    end
                    cnt_d   = FULL_BIT;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`endif
            S_STOP: begin
                if (cnt_q == '0) begin
                    if (line) begin
                        state_d = S_IDLE;
`ifdef UART_SNIFF_PARITY_EN
                        if (!par_bad_q) begin
`else
                        begin
`endif
                            if (fifo_full && !pop_now) begin
                                ovf_set = 1'b1;
                            end else begin
                                push = 1'b1;
                            end
                        end
                    end else begin
                        frame_set = 1'b1;
                        state_d   = S_WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_WAIT_IDLE: begin
                if (line) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Receiver state register.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            bit_q   <= '0;
`ifdef UART_SNIFF_PARITY_EN
            par_bad_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
`ifdef UART_SNIFF_PARITY_EN
            par_bad_q <= par_bad_d;
`endif
        end
    end

    // Sticky error flags; a set event wins over a coincident clear.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            frame_err <= 1'b0;
            ovf_err   <= 1'b0;
        end else begin
            if (frame_set) begin
                frame_err <= 1'b1;
            end else if (err_clr) begin
                frame_err <= 1'b0;
            end
            if (ovf_set) begin
                ovf_err <= 1'b1;
            end else if (err_clr) begin
                ovf_err <= 1'b0;
            end
        end
    end

    uart_sniff_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_in    (clk_in),
        .rst       (rst),
        .push      (push),
        .push_data (shift_q),
        .pop       (rx_ready),
        .head      (rx_data),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (rx_count)
    );

endmodule

// File: tb/tb_uart_tx_sniffer.sv
// Directed bench for uart_tx_sniffer with CLKS_PER_BIT=8, FIFO_DEPTH=4.
module tb_uart_tx_sniffer;
  import uart_sniff_pkg::*;

  localparam int CPB   = 8;
  localparam int DEPTH = 4;
`ifdef UART_SNIFF_PARITY_EN
  localparam int STOP_SAMPLE = 86;
`else
  localparam int STOP_SAMPLE = 78;
`endif

  logic         clk_in = 1'b0;
  logic         rst = 1'b1;
  logic         uart_rx = 1'b1;
  logic         rx_ready = 1'b0;
  logic         err_clr = 1'b0;
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic [2:0]   rx_count;
  logic         frame_err;
  logic         ovf_err;
  sniff_state_e fsm_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];
`ifdef UART_SNIFF_PARITY_EN
  logic par_flip = 1'b0;
`endif

  uart_tx_sniffer #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .uart_rx   (uart_rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .rx_count  (rx_count),
    .frame_err (frame_err),
    .ovf_err   (ovf_err),
    .err_clr   (err_clr),
    .fsm_state (fsm_state)
  );

  // clock
  always #5 clk_in = ~clk_in;

  // watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // advance n rising edges, then step 1 time unit past the edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    uart_rx = b;
    tick(CPB);
  endtask

  task automatic idle(input int n);
    uart_rx = 1'b1;
    tick(n);
  endtask

  // start, 8 data bits LSB first, optional parity, stop; line left at stop_bit
  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_SNIFF_PARITY_EN
    drive_bit((^d) ^ par_flip);
`endif
    drive_bit(stop_bit);
  endtask

  task automatic pop_one;
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
  endtask

  task automatic reset_dut;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(4);
  endtask

  task automatic pop_expect(input string tag);
    logic [7:0] e;
    e = exp_q.pop_front();
    check_eq(tag, rx_data, e);
    pop_one;
  endtask

  initial begin
    // reset values
    tick(3);
    check_eq("rst_valid", rx_valid, 0);
    check_eq("rst_count", rx_count, 0);
    check_eq("rst_data", rx_data, 0);
    check_eq("rst_frame", frame_err, 0);
    check_eq("rst_ovf", ovf_err, 0);
    check_eq("rst_state", fsm_state, S_IDLE);
    rst = 1'b0;
    idle(10);

    // 1: two bytes queued, then one pop
    send_frame(8'h55, 1'b1); idle(4);
    send_frame(8'hA3, 1'b1); idle(4);
    check_eq("t1_count2", rx_count, 2);
    check_eq("t1_valid", rx_valid, 1);
    check_eq("t1_head55", rx_data, 8'h55);
    pop_one;
    check_eq("t1_headA3", rx_data, 8'hA3);
    check_eq("t1_count1", rx_count, 1);

    // 2: 3-cycle glitch is a false start
    uart_rx = 1'b0;
    tick(3);
    uart_rx = 1'b1;
    tick(2);
    check_eq("t2_in_start", fsm_state, S_START);
    tick(20);
    check_eq("t2_idle", fsm_state, S_IDLE);
    check_eq("t2_count", rx_count, 1);
    check_eq("t2_frame", frame_err, 0);
    pop_one;
    check_eq("t2_drained", rx_count, 0);

    // 3: bad stop bit, break held low, then recovery
    send_frame(8'h41, 1'b0);
    tick(40);
    check_eq("t3_frame", frame_err, 1);
    check_eq("t3_count", rx_count, 0);
    check_eq("t3_wait", fsm_state, S_WAIT_IDLE);
    idle(16);
    check_eq("t3_idle", fsm_state, S_IDLE);
    send_frame(8'h42, 1'b1); idle(4);
    check_eq("t3_data42", rx_data, 8'h42);
    check_eq("t3_count1", rx_count, 1);
    check_eq("t3_sticky", frame_err, 1);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check_eq("t3_clr", frame_err, 0);
    pop_one;

    // 4a: overflow, with err_clr coinciding with the overflow event
    for (int i = 1; i <= 4; i++) begin
      send_frame(8'(i), 1'b1);
      idle(4);
    end
    fork
      send_frame(8'h05, 1'b1);
      begin
        tick(STOP_SAMPLE);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
      end
    join
    idle(4);
    check_eq("t4_count", rx_count, 4);
    check_eq("t4_ovf", ovf_err, 1);
    check_eq("t4_head", rx_data, 8'h01);

    // 4b: pop coincides with the fifth stop sample
    reset_dut;
    check_eq("t4_rst_ovf", ovf_err, 0);
    for (int i = 1; i <= 4; i++) begin
      send_frame(8'(i), 1'b1);
      idle(4);
    end
    fork
      send_frame(8'h05, 1'b1);
      begin
        tick(STOP_SAMPLE);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
      end
    join
    idle(4);
    check_eq("t4b_count", rx_count, 4);
    check_eq("t4b_ovf", ovf_err, 0);
    exp_q = '{8'h02, 8'h03, 8'h04, 8'h05};
    while (exp_q.size() > 0) pop_expect("t4b_drain");
    check_eq("t4b_empty", rx_valid, 0);
    pop_one;
    check_eq("t4b_pop_empty", rx_count, 0);

    // 5: reset mid-DATA with a byte queued
    send_frame(8'h11, 1'b1); idle(4);
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    tick(3);
    check_eq("t5_in_data", fsm_state, S_DATA);
    rst = 1'b1;
    uart_rx = 1'b1;
    tick(2);
    rst = 1'b0;
    check_eq("t5_valid", rx_valid, 0);
    check_eq("t5_count", rx_count, 0);
    check_eq("t5_data", rx_data, 0);
    check_eq("t5_state", fsm_state, S_IDLE);
    idle(100);
    check_eq("t5_quiet", rx_count, 0);
    // reset while the line is low: must not decode after release
    uart_rx = 1'b0;
    tick(4);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(12);
    idle(100);
    check_eq("t5_low_count", rx_count, 0);
    check_eq("t5_low_state", fsm_state, S_IDLE);
    send_frame(8'h7E, 1'b1); idle(4);
    check_eq("t5_data7E", rx_data, 8'h7E);
    check_eq("t5_count1", rx_count, 1);

`ifdef UART_SNIFF_PARITY_EN
    // 6: even parity accept / reject
    reset_dut;
    send_frame(8'h07, 1'b1); idle(4);
    check_eq("t6_count", rx_count, 1);
    check_eq("t6_data", rx_data, 8'h07);
    check_eq("t6_frame_ok", frame_err, 0);
    par_flip = 1'b1;
    send_frame(8'h07, 1'b1); idle(4);
    par_flip = 1'b0;
    check_eq("t6_frame_bad", frame_err, 1);
    check_eq("t6_nopush", rx_count, 1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
